muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter HART_ID_W, default 1, hart tag width.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, destination-register tag width.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port muldiv_start  input  1  request valid; qualifies op, a, b and the tags.
REQ-007 SHALL have port muldiv_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports muldiv_a, muldiv_b  input  XLEN  rs1, rs2 operands.
REQ-009 SHALL have ports muldiv_hart_id  input  HART_ID_W and muldiv_rd  input  REG_ADDR_W  request tags.
REQ-010 SHALL have port muldiv_busy  output  1  operation in flight; start ignored.
REQ-011 SHALL have port muldiv_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port muldiv_result  output  XLEN  result, valid while done=1.
REQ-013 SHALL have ports muldiv_done_hart_id  output  HART_ID_W and muldiv_done_rd  output  REG_ADDR_W  tags of the completing request.

Function
REQ-014 SHALL accept a request at edge N iff muldiv_start=1 and busy=0; operands and tags captured at edge N; start while busy dropped silently.
REQ-015 SHALL implement FSM IDLE -> CALC (on accept) -> DONE (count exhausted or special case) -> IDLE; DONE lasts exactly one cycle.
REQ-016 SHALL drive busy=1 in CALC only; busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-017 SHALL compute iteratively, one bit per cycle: done=1 in the cycle after edge N+33 for all normal mul/div ops; busy=1 after edges N..N+32.
REQ-018 SHALL allow a new accept in the DONE cycle (back-to-back, throughput one op per 34 cycles).
REQ-019 SHALL take signed operands as magnitudes with sign fix-up at completion; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned; MUL returns product[31:0], MULH* product[63:32].
REQ-020 SHALL, divide by zero: DIV/DIVU result 0xFFFFFFFF, REM/REMU result = a; latency 1 (done after edge N+1).
REQ-021 SHALL, signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000, REM result 0; latency 1.
REQ-022 SHALL round DIV toward zero; REM sign follows dividend.
REQ-023 SHALL hold muldiv_result, done_hart_id, done_rd stable from DONE until next DONE.

Reset
REQ-024 SHALL on rst=1 force FSM IDLE, busy=0, done=0, result=0, done tags=0, counter=0, asynchronously.
REQ-025 SHALL abort any in-flight operation on reset mid-operation with no done pulse; first accept possible on first edge with rst=0.

Configuration
REQ-026 SHALL support macro MULDIV_FAST_MUL_EN: defined -> MUL/MULH/MULHSU/MULHU use a single 33x33 signed multiply, latency 1 (done after edge N+1); divides unchanged.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, use the iterative shift-add path of REQ-017 for all multiplies.

Structure
REQ-028 SHALL place op encodings, FSM state enum and the 34-cycle count constant in shared package muldiv_pkg; XLEN/HART_ID_W/REG_ADDR_W defaults track defines.vh.
REQ-029 SHALL isolate the restoring divider datapath (quotient/remainder shift registers) in sub-module muldiv_div_core; FSM, sign handling and multiply stay in muldiv_unit.

Verification
REQ-030 SHALL cover MUL a=7 b=-3, tags hart1/rd=5 -> done after edge N+33 (N+1 if fast), result 0xFFFFFFEB, done_hart_id=1, done_rd=5.
REQ-031 SHALL cover MULH/MULHSU/MULHU a=0x80000000 b=0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF.
REQ-032 SHALL cover DIV a=-7 b=2 -> -3 (0xFFFFFFFD); REM -> -1; DIVU a=100 b=7 -> 14; REMU -> 2.
REQ-033 SHALL cover DIVU a=5 b=0 -> 0xFFFFFFFF and DIV 0x80000000/0xFFFFFFFF -> 0x80000000, both done after edge N+1.
REQ-034 SHALL cover start asserted while busy -> ignored, single done; new start in DONE cycle -> accepted.
REQ-035 SHALL cover rst pulse at cycle 10 of a DIV -> busy=0, no done, next request completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states,
// width defaults and the fixed iteration count.
package muldiv_pkg;

   // Defaults mirror the project-wide widths in defines.vh.
   localparam int XLEN_DEF       = 32;
   localparam int HART_ID_W_DEF  = 1;
   localparam int REG_ADDR_W_DEF = 5;

   // Accept cycle + 32 one-bit steps + sign fix-up cycle.
   localparam int MULDIV_CYCLES  = 34;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step.
// Quotient and partial remainder live in shift registers; load has priority over step.
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] divisor_q;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // A set top bit of diff is a borrow: the divisor did not fit this step.
   assign shifted = {remainder, quotient[XLEN-1]};
   assign diff    = shifted - {1'b0, divisor_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         divisor_q <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         divisor_q <= divisor;
      end else if (step) begin
         if (!diff[XLEN]) begin
            remainder <= diff[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b1};
         end else begin
            remainder <= shifted[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with tagged requests and a one-cycle done pulse.
// Define MULDIV_FAST_MUL_EN to complete multiplies with a single 33x33 multiply in one cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int HART_ID_W  = HART_ID_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  muldiv_start,
   input  logic [2:0]            muldiv_op,
   input  logic [XLEN-1:0]       muldiv_a,
   input  logic [XLEN-1:0]       muldiv_b,
   input  logic [HART_ID_W-1:0]  muldiv_hart_id,
   input  logic [REG_ADDR_W-1:0] muldiv_rd,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [XLEN-1:0]       muldiv_result,
   output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
   output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

   localparam int              CNT_W    = $clog2(MULDIV_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_CYCLES - 2);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e         state;
   logic [CNT_W-1:0]      cnt;
   muldiv_op_e            op_q;
   logic                  neg_q, special_q, fast_q;
   logic [XLEN-1:0]       special_res_q;
   logic [2*XLEN-1:0]     mcand_q, prod_q;
   logic [XLEN-1:0]       mplier_q;
   logic [HART_ID_W-1:0]  hart_q;
   logic [REG_ADDR_W-1:0] rd_q;

   muldiv_op_e      op_in;
   logic            accept, finish, a_sgn, b_sgn, neg_in, div_zero, div_ovf, fast_sel;
   logic [XLEN-1:0] mag_a, mag_b, special_res, quo, rem, final_res;
   logic [2*XLEN-1:0] mul_mag, signed_prod;

   assign op_in  = muldiv_op_e'(muldiv_op);
   assign accept = muldiv_start && (state != ST_CALC);
   assign finish = (state == ST_CALC) && (special_q || fast_q || (cnt == LAST_CNT));

   // Request decode: operand signedness, magnitudes, and the one-cycle special cases.
   always_comb begin
      a_sgn    = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && muldiv_a[XLEN-1];
      b_sgn    = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && muldiv_b[XLEN-1];
      mag_a    = a_sgn ? -muldiv_a : muldiv_a;
      mag_b    = b_sgn ? -muldiv_b : muldiv_b;
      neg_in   = (op_in == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
      div_zero = muldiv_op[2] && (muldiv_b == '0);
      div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (muldiv_a == INT_MIN) && (muldiv_b == '1);
      special_res = '0;
      if (div_zero)
         special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : muldiv_a;
      else if (div_ovf)
         special_res = (op_in == OP_DIV) ? INT_MIN : '0;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = (2*XLEN)'($signed({1'b0, mcand_q[XLEN-1:0]}) * $signed({1'b0, mplier_q}));
   assign mul_mag   = fast_q ? fast_prod : prod_q;
   assign fast_sel  = ~muldiv_op[2];
`else
   assign mul_mag   = prod_q;
   assign fast_sel  = 1'b0;
`endif

   // Sign fix-up applied once, at completion, to the magnitude results.
   always_comb begin
      signed_prod = neg_q ? -mul_mag : mul_mag;
      case (op_q)
         OP_MUL:                        final_res = signed_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  final_res = signed_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               final_res = neg_q ? -quo : quo;
         default:                       final_res = neg_q ? -rem : rem;
      endcase
      if (special_q)
         final_res = special_res_q;
   end

   muldiv_div_core #(.XLEN(XLEN)) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .step      ((state == ST_CALC) && !finish),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= ST_IDLE;
         cnt                 <= '0;
         op_q                <= OP_MUL;
         neg_q               <= 1'b0;
         special_q           <= 1'b0;
         fast_q              <= 1'b0;
         special_res_q       <= '0;
         mcand_q             <= '0;
         prod_q              <= '0;
         mplier_q            <= '0;
         hart_q              <= '0;
         rd_q                <= '0;
         muldiv_busy         <= 1'b0;
         muldiv_done         <= 1'b0;
         muldiv_result       <= '0;
         muldiv_done_hart_id <= '0;
         muldiv_done_rd      <= '0;
      end else begin
         muldiv_done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  state         <= ST_CALC;
                  muldiv_busy   <= 1'b1;
                  cnt           <= '0;
                  op_q          <= op_in;
                  neg_q         <= neg_in;
                  special_q     <= div_zero || div_ovf;
                  special_res_q <= special_res;
                  fast_q        <= fast_sel;
                  mcand_q       <= {{XLEN{1'b0}}, mag_a};
                  mplier_q      <= mag_b;
                  prod_q        <= '0;
                  hart_q        <= muldiv_hart_id;
                  rd_q          <= muldiv_rd;
               end else begin
                  state       <= ST_IDLE;
                  muldiv_busy <= 1'b0;
               end
            end
            ST_CALC: begin
               if (finish) begin
                  state               <= ST_DONE;
                  muldiv_busy         <= 1'b0;
                  muldiv_done         <= 1'b1;
                  muldiv_result       <= final_res;
                  muldiv_done_hart_id <= hart_q;
                  muldiv_done_rd      <= rd_q;
               end else begin
                  cnt      <= cnt + 1'b1;
                  if (mplier_q[0])
                     prod_q <= prod_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               muldiv_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases plus randomized ops
// checked against an arithmetic reference model, including latency and tags.
module tb_muldiv_unit;

   localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   logic            clk, rst;
   logic            muldiv_start;
   logic [2:0]      muldiv_op;
   logic [XLEN-1:0] muldiv_a, muldiv_b;
   logic [0:0]      muldiv_hart_id;
   logic [4:0]      muldiv_rd;
   logic            muldiv_busy, muldiv_done;
   logic [XLEN-1:0] muldiv_result;
   logic [0:0]      muldiv_done_hart_id;
   logic [4:0]      muldiv_done_rd;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [0:0]      hart;
      logic [4:0]      rd;
      int              acc_edge;
      int              lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total_cnt = 0;
   int   pass_cnt  = 0;
   int   edge_cnt  = 0;

   muldiv_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .muldiv_start        (muldiv_start),
      .muldiv_op           (muldiv_op),
      .muldiv_a            (muldiv_a),
      .muldiv_b            (muldiv_b),
      .muldiv_hart_id      (muldiv_hart_id),
      .muldiv_rd           (muldiv_rd),
      .muldiv_busy         (muldiv_busy),
      .muldiv_done         (muldiv_done),
      .muldiv_result       (muldiv_result),
      .muldiv_done_hart_id (muldiv_done_hart_id),
      .muldiv_done_rd      (muldiv_done_rd)
   );

   // Clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: RV32M semantics written with 64-bit integer arithmetic.
   function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                                   input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [XLEN-1:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (op)
         3'd0: begin p = sa * sb;           r = p[31:0];  end
         3'd1: begin p = sa * sb;           r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub;           r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; end
         end
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (b == 0) r = a;
            else begin p = ua % ub; r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (!op[2] && FAST_MUL) return 1;
      return 33;
   endfunction

   // Driver: called at a negedge; waits for busy=0, drives one start, returns at the next negedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [0:0] hart, input logic [4:0] rd, input logic [31:0] res);
      int   waited = 0;
      exp_t e;
      while (muldiv_busy && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("issue_wait_bound", 64'(waited < 200), 64'd1);
      muldiv_start   = 1'b1;
      muldiv_op      = op;
      muldiv_a       = a;
      muldiv_b       = b;
      muldiv_hart_id = hart;
      muldiv_rd      = rd;
      e.res      = res;
      e.hart     = hart;
      e.rd       = rd;
      e.acc_edge = edge_cnt + 1;
      e.lat      = ref_latency(op, a, b);
      exp_q.push_back(e);
      @(negedge clk);
      muldiv_start = 1'b0;
      check("busy_after_accept", 64'(muldiv_busy), 64'd1);
   endtask

   task automatic issue_rand();
      logic [2:0]  op;
      logic [31:0] v[2];
      op = 3'($urandom_range(0, 7));
      for (int i = 0; i < 2; i++) begin
         case ($urandom_range(0, 5))
            0:       v[i] = 32'h0;
            1:       v[i] = 32'h8000_0000;
            2:       v[i] = 32'hFFFF_FFFF;
            3:       v[i] = 32'($urandom_range(0, 20));
            default: v[i] = $urandom;
         endcase
      end
      issue(op, v[0], v[1], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ref_result(op, v[0], v[1]));
   endtask

   // Monitor: pops the scoreboard whenever the unit presents a completion.
   always @(negedge clk) begin
      if (!rst && muldiv_done) begin
         check("busy_low_in_done", 64'(muldiv_busy), 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result",  64'(muldiv_result), 64'(mon_e.res));
            check("hart_id", 64'(muldiv_done_hart_id), 64'(mon_e.hart));
            check("rd",      64'(muldiv_done_rd), 64'(mon_e.rd));
            check("latency", 64'(edge_cnt - mon_e.acc_edge), 64'(mon_e.lat));
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1;
      muldiv_start = 1'b0;
      muldiv_op = '0;
      muldiv_a = '0;
      muldiv_b = '0;
      muldiv_hart_id = '0;
      muldiv_rd = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   64'(muldiv_busy), 64'd0);
      check("rst_done",   64'(muldiv_done), 64'd0);
      check("rst_result", 64'(muldiv_result), 64'd0);
      check("rst_tags",   64'({muldiv_done_hart_id, muldiv_done_rd}), 64'd0);
      rst = 1'b0;

      // Directed corner cases (issued back-to-back, so each lands in the prior DONE cycle)
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd5, 32'hFFFF_FFEB);
      issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd1, 32'h0000_0000);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'h8000_0000);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd3, 32'h7FFF_FFFF);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd4, 32'hFFFF_FFFD);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd6, 32'hFFFF_FFFF);
      issue(3'd5, 32'd100, 32'd7, 1'b1, 5'd7, 32'd14);
      issue(3'd7, 32'd100, 32'd7, 1'b0, 5'd8, 32'd2);
      issue(3'd5, 32'd5, 32'd0, 1'b1, 5'd9, 32'hFFFF_FFFF);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd10, 32'h8000_0000);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd11, 32'h0);
      issue(3'd7, 32'd1234, 32'd0, 1'b0, 5'd12, 32'd1234);

      // Start pulses while busy must be dropped without a second completion
      issue(3'd5, 32'd1000, 32'd9, 1'b1, 5'd13, 32'd111);
      repeat (5) begin
         muldiv_start = 1'b1;
         muldiv_op    = 3'($urandom_range(0, 7));
         muldiv_a     = $urandom;
         muldiv_b     = $urandom;
         @(negedge clk);
      end
      muldiv_start = 1'b0;

      // Reset in the middle of a divide aborts it silently
      issue(3'd4, 32'd1000, 32'd3, 1'b1, 5'd14, 32'd333);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy",   64'(muldiv_busy), 64'd0);
      check("midrst_done",   64'(muldiv_done), 64'd0);
      check("midrst_result", 64'(muldiv_result), 64'd0);
      check("midrst_tags",   64'({muldiv_done_hart_id, muldiv_done_rd}), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(3'd4, 32'hFFFF_FC18, 32'd3, 1'b0, 5'd15, 32'hFFFF_FEB3);

      // Randomized traffic against the reference model
      repeat (40) issue_rand();

      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
